// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution pipeline: output-mode encodings,
// Sobel reset kernels and the minimum accumulator width rule.
package conv_pkg;

    localparam logic [1:0] MODE_PACKED = 2'd0;
    localparam logic [1:0] MODE_MAG    = 2'd1;
    localparam logic [1:0] MODE_THRESH = 2'd2;

    // Row-major, index 0 = top-left.
    localparam int SOBEL_X [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int SOBEL_Y [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    // Nine products of DATA_W x COEF_W bits need four guard bits to sum safely.
    function automatic int acc_w_min(input int data_w, input int coef_w);
        return data_w + coef_w + 4;
    endfunction

endpackage

// File: rtl/conv3x3_dot.sv
// 9-tap signed dot product: registered products (S1) then a registered sum (S2).
// Both stages advance only when en is high so the caller can stall the pipe.
module conv3x3_dot #(
    parameter int DATA_W = 9,
    parameter int COEF_W = 4,
    parameter int ACC_W  = 17
) (
    input  logic                clk,
    input  logic                en,
    input  logic [9*DATA_W-1:0] samples,
    input  logic [9*COEF_W-1:0] coefs,
    output logic [ACC_W-1:0]    acc
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod_p1 [9];
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  sum_p2;

    // S1: operands are widened before multiplying so the product is exact.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < 9; k++) begin
                prod_p1[k] <= PROD_W'($signed(samples[k*DATA_W +: DATA_W]))
                            * PROD_W'($signed(coefs[k*COEF_W +: COEF_W]));
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < 9; k++) begin
            sum_c = sum_c + ACC_W'(prod_p1[k]);
        end
    end

    // S2
    always_ff @(posedge clk) begin
        if (en) begin
            sum_p2 <= sum_c;
        end
    end

    assign acc = sum_p2;

endmodule

// File: rtl/conv3x3_pipe.sv
// Three-stage 3x3 convolution with two programmable kernels and selectable output
// format. Define CONV3X3_SAT_EN to saturate packed fields / clip magnitude instead of truncating.
module conv3x3_pipe
    import conv_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int COEF_W = 4,
    parameter int ACC_W  = acc_w_min(DATA_W, COEF_W),
    parameter int OUT_W  = 32
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                win_valid,
    output logic                win_ready,
    input  logic [9*DATA_W-1:0] win_data,
    input  logic [1:0]          mode,
    input  logic [ACC_W:0]      thresh,
    input  logic                coef_we,
    input  logic                coef_sel,
    input  logic [3:0]          coef_idx,
    input  logic [COEF_W-1:0]   coef_wdata,
    output logic [OUT_W-1:0]    pixel_out,
    output logic                conv_valid,
    input  logic                write_ready
);
    localparam int HALF   = OUT_W / 2;
    localparam int EXT_W  = ACC_W + HALF;
    localparam int WIDE_W = ACC_W + OUT_W + 1;
`ifdef CONV3X3_SAT_EN
    localparam logic signed [EXT_W-1:0] FIELD_MAX = {{(ACC_W+1){1'b0}}, {(HALF-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] FIELD_MIN = ~FIELD_MAX;
    localparam logic [WIDE_W-1:0]       MAG_MAX   = {{(ACC_W+1){1'b0}}, {OUT_W{1'b1}}};
`endif

    logic signed [COEF_W-1:0] kx [9];
    logic signed [COEF_W-1:0] ky [9];
    logic [9*COEF_W-1:0]      kx_flat;
    logic [9*COEF_W-1:0]      ky_flat;
    logic                     en;
    logic                     vld_p1, vld_p2;
    logic [1:0]               mode_p1, mode_p2;
    logic [ACC_W:0]           thresh_p1, thresh_p2;
    logic signed [ACC_W-1:0]  gx_p2, gy_p2;

    function automatic logic [HALF-1:0] pack_field(input logic signed [ACC_W-1:0] v);
        logic signed [EXT_W-1:0] ext;
        ext = EXT_W'(v);
`ifdef CONV3X3_SAT_EN
        if (ext > FIELD_MAX)
            ext = FIELD_MAX;
        else if (ext < FIELD_MIN)
            ext = FIELD_MIN;
`endif
        return ext[HALF-1:0];
    endfunction

    // One extra bit so the most negative accumulator value has a representable magnitude.
    function automatic logic [ACC_W:0] abs_ext(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] e;
        e = (ACC_W+1)'(v);
        return e[ACC_W] ? -e : e;
    endfunction

    function automatic logic [OUT_W-1:0] mag_out(input logic [ACC_W:0] m);
        logic [WIDE_W-1:0] wide;
        wide = WIDE_W'(m);
`ifdef CONV3X3_SAT_EN
        if (wide > MAG_MAX)
            wide = MAG_MAX;
`endif
        return wide[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] fmt(input logic [1:0] m,
                                             input logic signed [ACC_W-1:0] gx,
                                             input logic signed [ACC_W-1:0] gy,
                                             input logic [ACC_W:0] th);
        logic [ACC_W:0]   mag;
        logic [OUT_W-1:0] res;
        mag = abs_ext(gx) + abs_ext(gy);
        case (m)
            MODE_MAG:    res = mag_out(mag);
            MODE_THRESH: res = (mag >= th) ? OUT_W'(8'hFF) : {OUT_W{1'b0}};
            default:     res = {pack_field(gx), pack_field(gy)};  // packed; code 3 aliases it
        endcase
        return res;
    endfunction

    assign en        = !(conv_valid && !write_ready);
    assign win_ready = en;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < 9; k++) begin
                kx[k] <= COEF_W'(SOBEL_X[k]);
                ky[k] <= COEF_W'(SOBEL_Y[k]);
            end
        end else if (coef_we && coef_idx < 4'd9) begin
            if (coef_sel)
                ky[coef_idx] <= coef_wdata;
            else
                kx[coef_idx] <= coef_wdata;
        end
    end

    always_comb begin
        kx_flat = '0;
        ky_flat = '0;
        for (int k = 0; k < 9; k++) begin
            kx_flat[k*COEF_W +: COEF_W] = kx[k];
            ky_flat[k*COEF_W +: COEF_W] = ky[k];
        end
    end

    // S1 / S2: products and sums live in the dot units; mode and threshold ride alongside.
    conv3x3_dot #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_dot_x (
        .clk     (clk),
        .en      (en),
        .samples (win_data),
        .coefs   (kx_flat),
        .acc     (gx_p2)
    );

    conv3x3_dot #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_dot_y (
        .clk     (clk),
        .en      (en),
        .samples (win_data),
        .coefs   (ky_flat),
        .acc     (gy_p2)
    );

    always_ff @(posedge clk) begin
        if (en) begin
            mode_p1   <= mode;
            thresh_p1 <= thresh;
            mode_p2   <= mode_p1;
            thresh_p2 <= thresh_p1;
        end
    end

    // S3: formatted output register; valids advance with the data.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            conv_valid <= 1'b0;
            pixel_out  <= '0;
        end else if (en) begin
            vld_p1     <= win_valid;
            vld_p2     <= vld_p1;
            conv_valid <= vld_p2;
            pixel_out  <= fmt(mode_p2, gx_p2, gy_p2, thresh_p2);
        end
    end

endmodule

// File: doc/conv3x3_pipe.md
Name: conv3x3_pipe

Overview:
- Parametrised successor to the fixed Sobel convolution stage: 3x3 window in, two programmable kernels (KX, KY) applied per window.
- Output format is selectable: packed Gx/Gy, gradient magnitude, or thresholded binary edge.
- Three-stage pipeline with full valid/ready backpressure. Sits between the line-buffer/window generator and the write-back DMA.

Parameters:
- DATA_W, 9, signed width of each window sample.
- COEF_W, 4, signed width of each kernel coefficient.
- ACC_W, 17, signed accumulator width; must be >= DATA_W+COEF_W+4.
- OUT_W, 32, pixel_out width; even, and >= ACC_W+1.

Ports:
- clk  in  1  clock
- rstb  in  1  async active-low reset
- win_valid  in  1  window valid
- win_ready  out  1  window accepted when win_valid && win_ready
- win_data  in  9*DATA_W  signed samples; sample k (0..8, row-major, 0=top-left) at [k*DATA_W +: DATA_W]
- mode  in  2  0=packed, 1=magnitude, 2=threshold, 3=reserved (acts as 0); sampled with window
- thresh  in  ACC_W+1  unsigned edge threshold; sampled with window
- coef_we  in  1  coefficient write strobe
- coef_sel  in  1  0=KX, 1=KY
- coef_idx  in  4  coefficient index 0..8
- coef_wdata  in  COEF_W  signed coefficient value
- pixel_out  out  OUT_W  result
- conv_valid  out  1  result valid
- write_ready  in  1  downstream ready

Behaviour:
- Clock and reset: one clock, clk; reset rstb is asynchronous, active-low.
- Reset values:
  - pixel_out=0, conv_valid=0, all internal stage valids=0.
  - KX = {-1,0,1,-2,0,2,-1,0,1}, KY = {-1,-2,-1,0,0,0,1,2,1}.
  - win_ready=1 once out of reset. Reset mid-operation discards all in-flight windows.
- Pipeline:
  - S1 registers 18 signed products win[k]*K[k].
  - S2 registers gx=sum(KX products) and gy=sum(KY products), both ACC_W signed.
  - S3 registers the formatted pixel_out and conv_valid.
  - Latency: window accepted at cycle N -> conv_valid at N+3 with no stall. Throughput is 1 window/cycle.
- Stall:
  - en = !(conv_valid && !write_ready). Every stage register, including the valid bits, updates only when en=1.
  - win_ready = en, combinational.
  - pixel_out and conv_valid are held stable while stalled.
  - A bubble (stage valid=0) still advances when en=1.
- Format (S3):
  - mode0: pixel_out = {gx[OUT_W/2-1:0], gy[OUT_W/2-1:0]}; plain truncation.
  - mode1: mag = |gx|+|gy|, ACC_W+1 unsigned; pixel_out = zero-extended mag.
  - mode2: pixel_out = (mag >= thresh) ? 'hFF : 0.
- Coefficients:
  - When coef_we=1, the coefficient addressed by coef_sel and coef_idx is written at the clock edge.
  - coef_idx > 8 is ignored.
  - A write does not affect windows already past S1. A window accepted in the same cycle as a write uses the old value.
  - Writes are allowed during a stall.
- Arithmetic: all sums are signed with sign extension; no overflow is possible given the ACC_W rule.

Optional Feature:
- Macro: CONV3X3_SAT_EN.
- Defined: in mode0, gx and gy each saturate to the signed OUT_W/2 range instead of truncating. In mode1, mag clips to the OUT_W-bit unsigned maximum (only matters if ACC_W+1 > OUT_W).
- Undefined: plain truncation as specified above.

Decomposition:
- Package conv_pkg holds:
  - mode encodings MODE_PACKED/MODE_MAG/MODE_THRESH;
  - Sobel default coefficient constants;
  - the ACC_W derivation function.
- One sub-module, conv3x3_dot: 9-tap signed multiply plus registered adder tree. Instantiated twice (KX, KY), sharing the stall enable.

Test Plan:
- Default kernels, mode0, all samples = 5 -> pixel_out = 0x0000_0000 at N+3.
- Default kernels, mode0, left column 0, middle column 0, right column 10 -> gx=40, gy=0 -> pixel_out = 0x0028_0000.
- Same window, mode1 -> 0x0000_0028. Mode2 with thresh=40 -> 0xFF; with thresh=41 -> 0x00.
- Stream 4 windows back-to-back; hold write_ready=0 for 3 cycles once the first result is out:
  - win_ready drops the same cycle;
  - pixel_out is held stable;
  - all 4 results arrive in order with none lost or duplicated.
- Write KX all +1 (9 writes), then a window of all 3 -> gx=27. A write with coef_idx=9 leaves the kernels unchanged.
- OUT_W=18, mode0, left column 0, middle column 0, right column 255 -> gx=1020:
  - without CONV3X3_SAT_EN, gx field = 0x1FC (truncation, -4);
  - with CONV3X3_SAT_EN, gx field = 0x0FF.
- Assert rstb low mid-stream -> conv_valid=0 immediately and kernels reset to Sobel.
